card_sprite_renderer: RTL and testbench

- Consumer side of the card image ROM interface: drives `addrA` into a 1-cycle-latency synchronous card ROM and consumes its `dout`.
- Overlays one card sprite on the VGA timing/pixel stream.
- Includes a deal animation that slides the card from the deck position to a target position, one step per frame.
- Sits in the VGA pipeline between the background/table drawer and the next overlay stage; one instance per dealt card.

---
 rtl/card_sprite_renderer.sv | 162 ++++++++++++++++
 tb/tb_card_sprite_renderer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/card_sprite_renderer.sv
// Card sprite overlay for the VGA pixel stream: reads a 1-cycle-latency card ROM and
// slides the card from the deck to its target, one step per frame.
module card_sprite_renderer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int CARD_W     = 48,
    parameter int CARD_H     = 64,
    parameter int DECK_X     = 900,
    parameter int DECK_Y     = 40,
    parameter int STEP       = 8,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = 12'hF0F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hide,
    input  logic [10:0]           target_x,
    input  logic [10:0]           target_y,
    input  logic [10:0]           hcount_in,
    input  logic [10:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [DATA_WIDTH-1:0] rgb_in,
    output logic [ADDR_WIDTH-1:0] addrA,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic [10:0]           hcount_out,
    output logic [10:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, MOVING, PLACED} state_t;

    state_t      state, state_nx;
    logic [10:0] cur_x, cur_y, tgt_x, tgt_y;
    logic [10:0] cur_x_nx, cur_y_nx, tgt_x_nx, tgt_y_nx;
    logic        done_nx;
    logic        vblnk_prev;
    logic        frame_tick;

    // Move one axis toward its target, snapping when within one step.
    function automatic logic [10:0] step_axis(input logic [10:0] cur, input logic [10:0] tgt);
        logic signed [11:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff <= STEP && diff >= -STEP) return tgt;
        else if (diff > 0)                 return cur + 11'(STEP);
        else                               return cur - 11'(STEP);
    endfunction

    assign frame_tick = vblnk_in & ~vblnk_prev;
    assign busy       = (state == MOVING);

    always_comb begin
        state_nx = state;
        cur_x_nx = cur_x;
        cur_y_nx = cur_y;
        tgt_x_nx = tgt_x;
        tgt_y_nx = tgt_y;
        done_nx  = 1'b0;
        if (hide) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, PLACED: begin
                    if (start) begin
                        state_nx = MOVING;
                        tgt_x_nx = target_x;
                        tgt_y_nx = target_y;
                        cur_x_nx = 11'(DECK_X);
                        cur_y_nx = 11'(DECK_Y);
                    end
                end
                MOVING: begin
                    if (frame_tick) begin
                        cur_x_nx = step_axis(cur_x, tgt_x);
                        cur_y_nx = step_axis(cur_y, tgt_y);
                        if (cur_x_nx == tgt_x && cur_y_nx == tgt_y) begin
                            state_nx = PLACED;
                            done_nx  = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_x      <= 11'(DECK_X);
            cur_y      <= 11'(DECK_Y);
            tgt_x      <= 11'(DECK_X);
            tgt_y      <= 11'(DECK_Y);
            done       <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_x      <= cur_x_nx;
            cur_y      <= cur_y_nx;
            tgt_x      <= tgt_x_nx;
            tgt_y      <= tgt_y_nx;
            done       <= done_nx;
            vblnk_prev <= vblnk_in;
        end
    end

    // Window ends are 12 bits wide so a card near the right edge cannot wrap.
    logic [11:0]           x_end, y_end;
    logic [10:0]           dx, dy;
    logic                  in_win;
    logic [ADDR_WIDTH-1:0] addr_calc;

    assign x_end     = {1'b0, cur_x} + 12'(CARD_W);
    assign y_end     = {1'b0, cur_y} + 12'(CARD_H);
    assign dx        = hcount_in - cur_x;
    assign dy        = vcount_in - cur_y;
    assign in_win    = (state != IDLE)
                       && (hcount_in >= cur_x) && ({1'b0, hcount_in} < x_end)
                       && (vcount_in >= cur_y) && ({1'b0, vcount_in} < y_end);
    assign addr_calc = ADDR_WIDTH'(32'(dy) * CARD_W + 32'(dx));

    // Timing bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk}.
    logic [25:0]           t1, t2, t3;
    logic [DATA_WIDTH-1:0] rgb1, rgb2;
    logic                  win1, win2;

    always_ff @(posedge clk) begin
        if (rst) begin
            t1      <= '0;
            t2      <= '0;
            t3      <= '0;
            rgb1    <= '0;
            rgb2    <= '0;
            rgb_out <= '0;
            win1    <= 1'b0;
            win2    <= 1'b0;
            addrA   <= '0;
        end else begin
            t1    <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
            rgb1  <= rgb_in;
            win1  <= in_win;
            addrA <= in_win ? addr_calc : '0;
            t2    <= t1;
            rgb2  <= rgb1;
            win2  <= win1;
            t3    <= t2;
            if (win2 && dout != KEY_COLOR && !t2[1] && !t2[0]) rgb_out <= dout;
            else                                               rgb_out <= rgb2;
        end
    end

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = t3;

endmodule

// File: tb/tb_card_sprite_renderer.sv
// Directed self-checking bench for card_sprite_renderer with a behavioural 1-cycle card ROM.
module tb_card_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hide;
    logic [10:0] target_x, target_y;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] addrA;
    logic [11:0] dout;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    int done_cnt;
    logic last_done;
    logic [11:0] exp_q[$];
    logic [11:0] rom_mem [0:4095];

    card_sprite_renderer dut (
        .clk(clk), .rst(rst), .start(start), .hide(hide),
        .target_x(target_x), .target_y(target_y),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .addrA(addrA), .dout(dout),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // card ROM: one cycle of read latency
    always @(posedge clk) dout <= rom_mem[addrA];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one frame: vblnk high for a cycle (the tick), then low
    task automatic frame();
        vblnk_in = 1'b1;
        step();
        last_done = done;
        done_cnt += int'(done);
        vblnk_in = 1'b0;
        step();
        done_cnt += int'(done);
    endtask

    task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] rgb, input logic hb,
                         input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
        hcount_in = h; vcount_in = v; rgb_in = rgb; hblnk_in = hb;
        step();
        check({tag, "_addr"}, 32'(addrA), 32'(exp_addr));
        hcount_in = 11'd2000; vcount_in = 11'd1000; rgb_in = 12'h000; hblnk_in = 1'b0;
        step();
        step();
        check({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
    endtask

    task automatic deal(input logic [10:0] tx, input logic [10:0] ty);
        target_x = tx; target_y = ty; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [11:0] e;
        for (int a = 0; a < 4096; a++) rom_mem[a] = 12'h0F0;
        rom_mem[0]    = 12'h5E7;
        rom_mem[250]  = 12'h0A5;
        rom_mem[251]  = 12'hF0F;
        rom_mem[3071] = 12'h9C1;

        // reset held 3 cycles with live stimulus
        rst = 1'b1; start = 1'b1; hide = 1'b0;
        target_x = 11'd100; target_y = 11'd200;
        hcount_in = 11'd110; vcount_in = 11'd205;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
        rgb_in = 12'hABC; done_cnt = 0; last_done = 1'b0;
        step(); step(); step();
        check("rst_addrA", 32'(addrA), 0);
        check("rst_hcount", 32'(hcount_out), 0);
        check("rst_vcount", 32'(vcount_out), 0);
        check("rst_syncs", 32'({hsync_out, vsync_out}), 0);
        check("rst_blanks", 32'({hblnk_out, vblnk_out}), 0);
        check("rst_rgb", 32'(rgb_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0; start = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;

        // idle pass-through latency of exactly 3 cycles
        for (int i = 0; i < 8; i++) begin
            rgb_in = 12'(i * 291 + 17);
            hcount_in = 11'(i * 7 + 3);
            exp_q.push_back(rgb_in);
            step();
            if (i >= 2) begin
                e = exp_q.pop_front();
                check("lat_rgb", 32'(rgb_out), 32'(e));
                check("lat_hcount", 32'(hcount_out), 32'((i - 2) * 7 + 3));
            end
        end
        check("idle_busy", 32'(busy), 0);

        // deal to (100,200): y arrives after 20 frames, x after 100
        deal(11'd100, 11'd200);
        check("deal_busy", 32'(busy), 1);
        for (int f = 1; f <= 100; f++) begin
            frame();
            if (f == 20) begin
                // x = 900 - 160 = 740, y = 200
                probe("mid_in", 11'd743, 11'd202, 12'h111, 1'b0, 12'd99, 12'h0F0);
                probe("mid_left", 11'd739, 11'd202, 12'h112, 1'b0, 12'd0, 12'h112);
            end
            if (f == 99) begin
                check("pre_arrive_done", 32'(done_cnt), 0);
                check("pre_arrive_busy", 32'(busy), 1);
            end
        end
        check("arrive_done_pulse", 32'(last_done), 1);
        check("arrive_done_count", 32'(done_cnt), 1);
        check("placed_busy", 32'(busy), 0);
        check("placed_done_low", 32'(done), 0);

        // addressing, transparency, blank, edges
        probe("pix", 11'd110, 11'd205, 12'h777, 1'b0, 12'd250, 12'h0A5);
        probe("key", 11'd111, 11'd205, 12'h3C3, 1'b0, 12'd251, 12'h3C3);
        probe("hblank", 11'd110, 11'd205, 12'h456, 1'b1, 12'd250, 12'h456);
        probe("corner_tl", 11'd100, 11'd200, 12'h888, 1'b0, 12'd0, 12'h5E7);
        probe("edge_r", 11'd148, 11'd205, 12'h222, 1'b0, 12'd0, 12'h222);
        probe("edge_b", 11'd110, 11'd264, 12'h223, 1'b0, 12'd0, 12'h223);
        probe("corner_br", 11'd147, 11'd263, 12'h224, 1'b0, 12'd3071, 12'h9C1);

        // start during MOVING is ignored: (500,40) reached in 50 frames
        done_cnt = 0;
        deal(11'd500, 11'd40);
        deal(11'd0, 11'd0);
        for (int f = 1; f <= 50; f++) frame();
        check("ignore_start_done", 32'(last_done), 1);
        check("ignore_start_count", 32'(done_cnt), 1);
        probe("at500", 11'd501, 11'd41, 12'h321, 1'b0, 12'd49, 12'h0F0);

        // hide and start together: hide wins
        done_cnt = 0;
        hide = 1'b1;
        deal(11'd300, 11'd300);
        hide = 1'b0;
        check("hide_busy", 32'(busy), 0);
        for (int f = 0; f < 5; f++) frame();
        check("hide_no_done", 32'(done_cnt), 0);
        probe("hide_gone", 11'd501, 11'd41, 12'h321, 1'b0, 12'd0, 12'h321);

        // reset in the middle of a deal
        deal(11'd100, 11'd200);
        for (int f = 0; f < 3; f++) frame();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        probe("midrst_gone", 11'd905, 11'd42, 12'h654, 1'b0, 12'd0, 12'h654);

        // target equal to deck: done on the first frame tick
        done_cnt = 0;
        deal(11'd900, 11'd40);
        probe("deck_draw", 11'd905, 11'd42, 12'h654, 1'b0, 12'd101, 12'h0F0);
        frame();
        check("deck_done", 32'(last_done), 1);
        check("deck_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
